// File: rtl/imem_pkg.sv
// ---------------------------------------------------------------------------
// imem_pkg
// Shared definitions for the instruction-memory fetch responder:
//   AW / DEPTH  - default word-address width and store depth (DEPTH = 2**AW)
//   NOP_INSTR   - instruction word returned for a faulting fetch
//   buf_state_t - occupancy of the 2-entry response buffer
//   resp_t      - one buffered response (fault flag + instruction word)
// ---------------------------------------------------------------------------
package imem_pkg;

  localparam int          AW        = 10;
  localparam int          DEPTH     = 1 << AW;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_FULL  = 2'd2
  } buf_state_t;

  typedef struct packed {
    logic        err;
    logic [31:0] instr;
  } resp_t;

endpackage : imem_pkg

// File: rtl/resp_fifo2.sv
// ---------------------------------------------------------------------------
// resp_fifo2
// Two-entry in-order response buffer with a flush that empties it.
// Occupancy is tracked by an EMPTY / ONE / FULL state; read and write
// pointers are single bits, so they wrap modulo 2 on their own.
// A push into FULL or a pop from EMPTY is ignored, so neither can corrupt
// the buffer regardless of what the caller drives.
//
// Ports
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   flush      in   drop every buffered entry; overrides push and pop
//   push       in   write push_data at the tail
//   push_data  in   entry to write
//   pop        in   retire the head entry
//   not_full   out  buffer can take a push this cycle
//   head_valid out  buffer holds at least one entry
//   head_data  out  oldest entry (all zeros while empty)
// ---------------------------------------------------------------------------
module resp_fifo2
  import imem_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  flush,
  input  logic  push,
  input  resp_t push_data,
  input  logic  pop,
  output logic  not_full,
  output logic  head_valid,
  output resp_t head_data
);

  buf_state_t state_q;
  buf_state_t state_d;
  logic       wr_ptr_q;
  logic       rd_ptr_q;
  logic       push_ok;
  logic       pop_ok;
  resp_t      entries [2];

  assign push_ok = push && (state_q != BUF_FULL) && !flush;
  assign pop_ok  = pop  && (state_q != BUF_EMPTY) && !flush;

  always_comb begin
    // NOTE: state_d gets a default before any branch so every path assigns
    // it; a missing default here is how latches get inferred.
    state_d = state_q;
    if (flush) begin
      state_d = BUF_EMPTY;
    end else if (push_ok && !pop_ok) begin
      state_d = (state_q == BUF_EMPTY) ? BUF_ONE : BUF_FULL;
    end else if (pop_ok && !push_ok) begin
      state_d = (state_q == BUF_FULL) ? BUF_ONE : BUF_EMPTY;
    end
    // push and pop together only happens in ONE and leaves it unchanged
  end

  // NOTE: sequential state uses non-blocking (<=) assignments so every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= BUF_EMPTY;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (flush) begin
        wr_ptr_q <= 1'b0;
        rd_ptr_q <= 1'b0;
      end else begin
        if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

  // NOTE: storage arrays carry no reset; their contents are only observed
  // through head_data, which is forced to zero whenever the buffer is empty.
  always_ff @(posedge clk) begin
    if (push_ok) entries[wr_ptr_q] <= push_data;
  end

  assign not_full   = (state_q != BUF_FULL);
  assign head_valid = (state_q != BUF_EMPTY);
  assign head_data  = head_valid ? entries[rd_ptr_q] : '0;

endmodule : resp_fifo2

// File: rtl/imem_fetch_responder.sv
// ---------------------------------------------------------------------------
// imem_fetch_responder
// Instruction store with a side-band loader and a valid/ready fetch port.
// An accepted fetch reads the store and lands in a 2-entry response buffer,
// so the response is visible one cycle after the accept. A flush (taken
// branch) discards every buffered response and blocks new requests for
// that cycle. DEPTH must equal 2**AW.
//
// Optional feature (define IMEM_ADDR_CHECK_EN):
//   a request with a misaligned byte address or with address bits above the
//   store range returns resp_err=1 and a NOP_INSTR word. Without it,
//   resp_err is tied 0 and those address bits are ignored.
//
// Ports
//   Clk         in   clock, all state updates on the rising edge
//   Reset       in   asynchronous active-low reset
//   req_valid   in   fetch request present
//   req_addr    in   byte address of the instruction
//   req_ready   out  a request can be accepted this cycle
//   resp_valid  out  head response present
//   resp_instr  out  instruction word of the head response
//   resp_err    out  head response is an address fault
//   resp_ready  in   requester takes the head response this cycle
//   flush       in   discard all buffered responses
//   ld_en       in   loader write strobe
//   ld_addr     in   loader word address
//   ld_data     in   loader write data
// ---------------------------------------------------------------------------
module imem_fetch_responder #(
  parameter int DEPTH = imem_pkg::DEPTH,
  parameter int AW    = imem_pkg::AW
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          req_valid,
  input  logic [31:0]   req_addr,
  output logic          req_ready,
  output logic          resp_valid,
  output logic [31:0]   resp_instr,
  output logic          resp_err,
  input  logic          resp_ready,
  input  logic          flush,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_addr,
  input  logic [31:0]   ld_data
);

  import imem_pkg::*;

  logic [31:0] mem [DEPTH];

  logic          accept;
  logic          fifo_not_full;
  logic [AW-1:0] fetch_idx;
  resp_t         fetch_resp;
  resp_t         head_data;

  // req_ready depends only on buffer state and flush, never on resp_ready
  // or req_valid, so it cannot form a combinational loop with the requester.
  assign req_ready = fifo_not_full && !flush;
  assign accept    = req_valid && req_ready;
  assign fetch_idx = req_addr[AW+1:2];

  // The store is never reset; a loaded program survives Reset.
  always_ff @(posedge Clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
  end

  // The fetch reads the store combinationally ahead of the edge, so a loader
  // write to the same word on the same edge returns the old data.
`ifdef IMEM_ADDR_CHECK_EN
  logic addr_fault;

  assign addr_fault = (req_addr[1:0] != 2'b00) || (req_addr[31:AW+2] != '0);

  always_comb begin
    fetch_resp.err   = addr_fault;
    fetch_resp.instr = addr_fault ? NOP_INSTR : mem[fetch_idx];
  end
`else
  logic unused_addr_bits;

  assign unused_addr_bits = ^{req_addr[31:AW+2], req_addr[1:0]};

  always_comb begin
    fetch_resp.err   = 1'b0;
    fetch_resp.instr = mem[fetch_idx];
  end
`endif

  resp_fifo2 u_resp_fifo2 (
    .clk        (Clk),
    .rst_n      (Reset),
    .flush      (flush),
    .push       (accept),
    .push_data  (fetch_resp),
    .pop        (resp_ready),
    .not_full   (fifo_not_full),
    .head_valid (resp_valid),
    .head_data  (head_data)
  );

  assign resp_instr = head_data.instr;

`ifdef IMEM_ADDR_CHECK_EN
  assign resp_err = head_data.err;
`else
  logic unused_head_err;

  assign unused_head_err = head_data.err;
  assign resp_err        = 1'b0;
`endif

endmodule : imem_fetch_responder

// File: tb/tb_imem_fetch_responder.sv
// ---------------------------------------------------------------------------
// tb_imem_fetch_responder
// Directed stimulus with a scoreboard: each request pushes its hand-computed
// expected response when it is accepted, and a monitor pops and compares on
// every response handshake. Directed checks cover reset, back-pressure,
// flush, read-before-write and address faults.
// ---------------------------------------------------------------------------
module tb_imem_fetch_responder;

  localparam int AW = 10;

  logic          Clk;
  logic          Reset;
  logic          req_valid;
  logic [31:0]   req_addr;
  logic          req_ready;
  logic          resp_valid;
  logic [31:0]   resp_instr;
  logic          resp_err;
  logic          resp_ready;
  logic          flush;
  logic          ld_en;
  logic [AW-1:0] ld_addr;
  logic [31:0]   ld_data;

  int n_checks = 0;
  int n_errors = 0;

  logic [32:0] exp_q [$];
  logic [32:0] cur_exp;

  imem_fetch_responder #(.DEPTH(1024), .AW(AW)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_instr (resp_instr),
    .resp_err   (resp_err),
    .resp_ready (resp_ready),
    .flush      (flush),
    .ld_en      (ld_en),
    .ld_addr    (ld_addr),
    .ld_data    (ld_data)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] actual,
                       input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic cycle();
    @(posedge Clk);
    #1;
  endtask

  task automatic load(input int unsigned a, input logic [31:0] d);
    ld_en   = 1'b1;
    ld_addr = a[AW-1:0];
    ld_data = d;
    cycle();
    ld_en   = 1'b0;
  endtask

  task automatic drive_req(input logic [31:0] addr, input logic [32:0] expv);
    req_valid = 1'b1;
    req_addr  = addr;
    cur_exp   = expv;
  endtask

  // Monitor: handshakes are sampled mid-cycle, away from the rising edge.
  always @(negedge Clk) begin
    if (Reset) begin
      if (flush) begin
        exp_q.delete();
      end else if (resp_valid && resp_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL resp_unexpected: got %h with no response pending",
                   {resp_err, resp_instr});
        end else begin
          check("resp_data", {31'b0, resp_err, resp_instr}, {31'b0, exp_q.pop_front()});
        end
      end
      if (req_valid && req_ready) exp_q.push_back(cur_exp);
    end
  end

  initial begin
    Reset      = 1'b1;
    req_valid  = 1'b0;
    req_addr   = '0;
    resp_ready = 1'b0;
    flush      = 1'b0;
    ld_en      = 1'b0;
    ld_addr    = '0;
    ld_data    = '0;
    cur_exp    = '0;

    // ---- reset state ----
    #2 Reset = 1'b0;
    #1;
    check("reset_resp_valid", 64'(resp_valid), 64'd0);
    check("reset_resp_instr", 64'(resp_instr), 64'd0);
    check("reset_resp_err",   64'(resp_err),   64'd0);
    cycle();
    cycle();
    Reset = 1'b1;
    #1;
    check("post_reset_req_ready",  64'(req_ready),  64'd1);
    check("post_reset_resp_valid", 64'(resp_valid), 64'd0);

    // ---- load program ----
    load(0, 32'd1);
    load(1, 32'd2);
    load(2, 32'd3);
    load(3, 32'd4);
    load(5, 32'h0000_DEAD);

    // ---- streaming: one response per cycle, latency 1 ----
    resp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_req(32'(4 * i), {1'b0, 32'(i + 1)});
      cycle();
      check($sformatf("stream_valid_%0d", i), 64'(resp_valid), 64'd1);
      check($sformatf("stream_instr_%0d", i), 64'(resp_instr), 64'(i + 1));
    end
    req_valid = 1'b0;
    cycle();
    check("stream_drained", 64'(resp_valid), 64'd0);

    // ---- back-pressure: fill, hold third request, release one ----
    resp_ready = 1'b0;
    drive_req(32'h0, {1'b0, 32'd1});
    cycle();
    drive_req(32'h4, {1'b0, 32'd2});
    cycle();
    check("full_req_ready", 64'(req_ready),  64'd0);
    check("full_head",      64'(resp_instr), 64'd1);
    drive_req(32'h8, {1'b0, 32'd3});
    cycle();
    check("held_req_ready",   64'(req_ready),  64'd0);
    check("held_head_stable", 64'(resp_instr), 64'd1);
    resp_ready = 1'b1;
    cycle();
    resp_ready = 1'b0;
    check("after_pop_req_ready", 64'(req_ready),  64'd1);
    check("after_pop_head",      64'(resp_instr), 64'd2);
    cycle();
    check("third_accepted_full", 64'(req_ready),  64'd0);
    check("third_valid",         64'(resp_valid), 64'd1);
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    cycle();
    cycle();
    check("bp_drained", 64'(resp_valid), 64'd0);

    // ---- flush in ONE with resp_ready high ----
    resp_ready = 1'b0;
    drive_req(32'h0, {1'b0, 32'd1});
    cycle();
    check("one_before_flush", 64'(resp_valid), 64'd1);
    drive_req(32'h4, {1'b0, 32'd2});
    flush      = 1'b1;
    resp_ready = 1'b1;
    #1;
    check("flush_req_ready", 64'(req_ready), 64'd0);
    cycle();
    flush     = 1'b0;
    req_valid = 1'b0;
    check("flush_empty", 64'(resp_valid), 64'd0);
    cycle();
    check("flush_no_accept", 64'(resp_valid), 64'd0);

    // ---- read-before-write on the same word ----
    ld_en   = 1'b1;
    ld_addr = 10'd5;
    ld_data = 32'hAAAA_0000;
    drive_req(32'h14, {1'b0, 32'h0000_DEAD});
    cycle();
    ld_en = 1'b0;
    check("rbw_old_data", 64'(resp_instr), 64'h0000_DEAD);
    drive_req(32'h14, {1'b0, 32'hAAAA_0000});
    cycle();
    check("rbw_new_data", 64'(resp_instr), 64'hAAAA_0000);
    req_valid = 1'b0;
    cycle();

    // ---- out-of-range / misaligned addresses ----
`ifdef IMEM_ADDR_CHECK_EN
    drive_req(32'h2, {1'b1, 32'h0});
    cycle();
    check("misaligned_err", 64'(resp_err), 64'd1);
    drive_req(32'h1000, {1'b1, 32'h0});
    cycle();
    check("range_err", 64'(resp_err), 64'd1);
`else
    drive_req(32'h2, {1'b0, 32'd1});
    cycle();
    check("misaligned_ignored", 64'(resp_instr), 64'd1);
    drive_req(32'h1000, {1'b0, 32'd1});
    cycle();
    check("range_ignored_err", 64'(resp_err), 64'd0);
`endif
    req_valid = 1'b0;
    cycle();

    // ---- reset while FULL ----
    resp_ready = 1'b0;
    drive_req(32'h4, {1'b0, 32'd2});
    cycle();
    drive_req(32'h8, {1'b0, 32'd3});
    cycle();
    check("prereset_full", 64'(req_ready), 64'd0);
    req_valid = 1'b0;
    #1 Reset = 1'b0;
    #1;
    check("midreset_resp_valid", 64'(resp_valid), 64'd0);
    check("midreset_resp_instr", 64'(resp_instr), 64'd0);
    exp_q.delete();
    cycle();
    Reset = 1'b1;
    #1;
    check("release_req_ready",  64'(req_ready),  64'd1);
    check("release_resp_valid", 64'(resp_valid), 64'd0);
    // store contents survive reset and the buffer restarts cleanly
    resp_ready = 1'b1;
    drive_req(32'hC, {1'b0, 32'd4});
    cycle();
    req_valid = 1'b0;
    check("postreset_fetch", 64'(resp_instr), 64'd4);
    cycle();
    cycle();
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_imem_fetch_responder

// File: doc/imem_fetch_responder.md
IMEM_FETCH_RESPONDER -- requirements
Module: imem_fetch_responder

Interface
REQ-001 Parameter: DEPTH, 1024, instruction words held in the internal store.
REQ-002 Parameter: AW, 10, word-address width; DEPTH SHALL equal 2**AW.
REQ-003 Port: Clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 Port: Reset  in  1  asynchronous, active-low reset.
REQ-005 Port: req_valid  in  1  fetch request present.
REQ-006 Port: req_addr  in  32  byte address of the instruction.
REQ-007 Port: req_ready  out  1  responder can accept a request this cycle.
REQ-008 Port: resp_valid  out  1  head response present.
REQ-009 Port: resp_instr  out  32  instruction word of the head response.
REQ-010 Port: resp_err  out  1  head response is an address fault.
REQ-011 Port: resp_ready  in  1  requester takes the head response this cycle.
REQ-012 Port: flush  in  1  discard all buffered responses (branch taken).
REQ-013 Port: ld_en  in  1  loader write strobe.
REQ-014 Port: ld_addr  in  AW  loader word address.
REQ-015 Port: ld_data  in  32  loader write data.

Function
REQ-016 Accept = req_valid && req_ready at a rising edge; pop = resp_valid && resp_ready at a rising edge.
REQ-017 On accept, mem[req_addr[AW+1:2]] SHALL be written, with its err bit, into a 2-entry in-order response buffer; resp_valid SHALL be high in the next cycle (latency 1).
REQ-018 Buffer FSM states: EMPTY, ONE, FULL.
- push only: EMPTY->ONE, ONE->FULL.
- pop only: FULL->ONE, ONE->EMPTY.
- push+pop in ONE: stays ONE.
REQ-019 req_ready SHALL be (state != FULL) && !flush; it SHALL have no combinational dependence on resp_ready or req_valid.
REQ-020 resp_valid SHALL be (state != EMPTY); resp_instr/resp_err SHALL show the oldest entry and SHALL be stable while resp_valid && !resp_ready.
REQ-021 Sustained req_valid and resp_ready SHALL give one response per cycle.
REQ-022 flush SHALL force state EMPTY at the edge, overriding any pop; no request is accepted during flush.
REQ-023 ld_en SHALL write ld_data to mem[ld_addr] at the edge.
REQ-024 A same-edge accept to the same word SHALL return the old data (read-before-write).
REQ-025 Pop from EMPTY and push into FULL SHALL be impossible by construction; buffer pointers SHALL wrap modulo 2.

Reset
REQ-026 Reset low SHALL immediately force: state EMPTY, pointers 0, resp_valid 0, resp_instr 0, resp_err 0.
- req_ready SHALL be 1 after reset release.
REQ-027 Memory contents SHALL NOT be cleared by reset.
REQ-028 Reset asserted mid-stream SHALL drop all buffered responses.

Configuration
REQ-029 With IMEM_ADDR_CHECK_EN defined, err SHALL be set for any accepted request with req_addr[1:0] != 0 or req_addr[31:AW+2] != 0; the stored instruction for it SHALL be 32'h0.
REQ-030 Without IMEM_ADDR_CHECK_EN, resp_err SHALL be tied 0 and the upper/lower address bits SHALL be ignored.

Structure
REQ-031 Package imem_pkg SHALL hold AW, DEPTH, the buffer-state enum and NOP_INSTR = 32'h0.
REQ-032 The 2-entry buffer SHALL be a sub-module named resp_fifo2; the store and loader SHALL stay in imem_fetch_responder.

Verification
REQ-033 Reset, load mem[0..3] = 1,2,3,4, requests to 0,4,8,12 with resp_ready=1 -> responses 1,2,3,4 on consecutive cycles, first one cycle after the first accept.
REQ-034 resp_ready=0 with two requests -> FULL, req_ready=0, third request held; resp_ready=1 for one cycle -> head 1 popped, third request accepted on the next edge.
REQ-035 Buffer ONE, flush and resp_ready both high -> EMPTY next cycle, resp_valid=0, no request accepted that cycle.
REQ-036 ld_en to word 5 with data 32'hAAAA0000 on the same edge as a fetch of 0x14 (old 32'hDEAD) -> response 32'hDEAD; a refetch of 0x14 -> 32'hAAAA0000.
REQ-037 With IMEM_ADDR_CHECK_EN, requests to 0x2 and 0x1000 -> resp_err=1, resp_instr=0; without it, 0x1000 -> mem[0], resp_err=0.
REQ-038 Reset asserted while FULL -> resp_valid drops immediately; after release, req_ready=1 and the buffer is empty.
